rvvi_host_cmd_decoder: RTL

//  Downstream consumer of the Ethernet MAC RX AXI-stream in the RVVI tracer top level.

---
 rtl/rvvi_host_cmd_decoder.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/rvvi_host_cmd_decoder.sv
// rvvi_host_cmd_decoder
//   Watches the Ethernet MAC RX AXI-stream and parses each frame once. It
//   decodes the host command frames TRIGIN, SLOWME and RATEIN. For each good
//   command frame it produces a one-cycle pulse, a registered argument word and
//   (for RATEIN) an updated inter-packet delay.
//
// Handshake: a beat transfers on every cycle where RvviAxiRvalid=1. The block
//   is always ready, so there is no tready. Cycles with Rvalid=0 hold all state.
//
// Frame layout (32-bit words, byte0 in [7:0]):
//   word0..2  HDR_PREFIX[95:0]
//   word3     [15:0] = HDR_PREFIX[111:96], [31:16] = command[15:0]
//   word4     command[47:16]
//   word5     argument
//   word6..   padding, ignored
//
// Ports:
//   clk, reset         core clock; synchronous active-high reset
//   RvviAxiR*          RX stream beat (data, strobes, last, valid)
//   TrigPulse          one-cycle pulse for a good TRIGIN frame
//   SlowPulse          one-cycle pulse for a good SLOWME frame
//   RatePulse          one-cycle pulse for a good RATEIN frame
//   CmdArg             argument of the last good command frame
//   RateValue          current inter-packet delay
//   FrameCnt, DropCnt  saturating statistics counters
//   dbg_state          current FSM state (0 HDR, 1 ARG, 2 DRAIN)
//
// Build option: define RVVI_CMD_STATS_EN to implement FrameCnt/DropCnt.
//   Without it, both outputs read 0 and no counter flops are built.
module rvvi_host_cmd_decoder #(
  parameter logic [111:0] HDR_PREFIX = 112'h005c_8f54_0000_1654_4502_1111_6843,
  parameter logic [47:0]  CMD_TRIG   = 48'h6e69_6769_7274,
  parameter logic [47:0]  CMD_SLOW   = 48'h656d_776f_6c73,
  parameter logic [47:0]  CMD_RATE   = 48'h6e69_6574_6172,
  parameter logic [31:0]  RATE_RESET = 32'd2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] RvviAxiRdata,
  input  logic [3:0]  RvviAxiRstrb,
  input  logic        RvviAxiRlast,
  input  logic        RvviAxiRvalid,
  output logic        TrigPulse,
  output logic        SlowPulse,
  output logic        RatePulse,
  output logic [31:0] CmdArg,
  output logic [31:0] RateValue,
  output logic [15:0] FrameCnt,
  output logic [15:0] DropCnt,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {S_HDR = 2'd0, S_ARG = 2'd1, S_DRAIN = 2'd2} state_t;

  // Command selector codes. SEL_NONE also means "no commit pending".
  localparam logic [1:0] SEL_NONE = 2'd0;
  localparam logic [1:0] SEL_TRIG = 2'd1;
  localparam logic [1:0] SEL_SLOW = 2'd2;
  localparam logic [1:0] SEL_RATE = 2'd3;

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [15:0] cmd_lo_q, cmd_lo_d;
  logic [1:0]  sel_q, sel_d;
  logic [31:0] arg_q, arg_d;

  logic        full_strb;
  logic        word_ok;
  logic [47:0] cmd_field;
  logic [1:0]  cmd_code;
  logic        commit;
  logic [1:0]  commit_sel;
  logic [31:0] commit_arg;
  logic        drop;

  assign full_strb = (RvviAxiRstrb == 4'hF);
  assign cmd_field = {RvviAxiRdata, cmd_lo_q};

  always_comb begin
    cmd_code = SEL_NONE;
    if (cmd_field == CMD_TRIG)      cmd_code = SEL_TRIG;
    else if (cmd_field == CMD_SLOW) cmd_code = SEL_SLOW;
    else if (cmd_field == CMD_RATE) cmd_code = SEL_RATE;
  end

  // Does the current header beat match what is expected at this index?
  always_comb begin
    word_ok = 1'b0;
    case (idx_q)
      3'd0:    word_ok = (RvviAxiRdata == HDR_PREFIX[31:0]);
      3'd1:    word_ok = (RvviAxiRdata == HDR_PREFIX[63:32]);
      3'd2:    word_ok = (RvviAxiRdata == HDR_PREFIX[95:64]);
      3'd3:    word_ok = (RvviAxiRdata[15:0] == HDR_PREFIX[111:96]);
      3'd4:    word_ok = (cmd_code != SEL_NONE);
      default: word_ok = 1'b0;
    endcase
    word_ok = word_ok && full_strb;
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cmd_lo_d   = cmd_lo_q;
    sel_d      = sel_q;
    arg_d      = arg_q;
    commit     = 1'b0;
    commit_sel = sel_q;
    commit_arg = arg_q;
    drop       = 1'b0;
    if (RvviAxiRvalid) begin
      case (state_q)
        S_HDR: begin
          if (idx_q == 3'd3) cmd_lo_d = RvviAxiRdata[31:16];
          if (RvviAxiRlast) begin
            // A frame that matched so far but ended early is a truncated
            // command. A frame that failed to match is foreign and not counted.
            drop    = word_ok;
            state_d = S_HDR;
            idx_d   = 3'd0;
            sel_d   = SEL_NONE;
          end else if (!word_ok) begin
            state_d = S_DRAIN;
            idx_d   = 3'd0;
            sel_d   = SEL_NONE;
          end else if (idx_q == 3'd4) begin
            state_d = S_ARG;
            idx_d   = 3'd0;
            sel_d   = cmd_code;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
        S_ARG: begin
          if (!full_strb) begin
            drop    = 1'b1;
            sel_d   = SEL_NONE;
            state_d = RvviAxiRlast ? S_HDR : S_DRAIN;
          end else if (RvviAxiRlast) begin
            commit     = 1'b1;
            commit_arg = RvviAxiRdata;
            sel_d      = SEL_NONE;
            state_d    = S_HDR;
          end else begin
            arg_d   = RvviAxiRdata;
            state_d = S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (RvviAxiRlast) begin
            commit  = (sel_q != SEL_NONE);
            sel_d   = SEL_NONE;
            state_d = S_HDR;
          end
        end
        default: begin
          state_d = S_HDR;
          idx_d   = 3'd0;
          sel_d   = SEL_NONE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_HDR;
      idx_q     <= 3'd0;
      cmd_lo_q  <= 16'd0;
      sel_q     <= SEL_NONE;
      arg_q     <= 32'd0;
      TrigPulse <= 1'b0;
      SlowPulse <= 1'b0;
      RatePulse <= 1'b0;
      CmdArg    <= 32'd0;
      RateValue <= RATE_RESET;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cmd_lo_q  <= cmd_lo_d;
      sel_q     <= sel_d;
      arg_q     <= arg_d;
      TrigPulse <= commit && (commit_sel == SEL_TRIG);
      SlowPulse <= commit && (commit_sel == SEL_SLOW);
      RatePulse <= commit && (commit_sel == SEL_RATE);
      if (commit) CmdArg <= commit_arg;
      // A zero delay is not a usable rate; keep the previous one.
      if (commit && (commit_sel == SEL_RATE) && (commit_arg != 32'd0))
        RateValue <= commit_arg;
    end
  end

  assign dbg_state = state_q;

`ifdef RVVI_CMD_STATS_EN
  logic [15:0] frame_cnt_q;
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt_q <= 16'd0;
      drop_cnt_q  <= 16'd0;
    end else begin
      if (commit && (frame_cnt_q != 16'hFFFF)) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (drop && (drop_cnt_q != 16'hFFFF))    drop_cnt_q  <= drop_cnt_q + 16'd1;
    end
  end

  assign FrameCnt = frame_cnt_q;
  assign DropCnt  = drop_cnt_q;
`else
  logic unused_stats;
  assign unused_stats = drop;
  assign FrameCnt     = 16'd0;
  assign DropCnt      = 16'd0;
`endif

endmodule
